reed_solomon_encoder: RTL and testbench

- Systematic RS(255,239) encoder over GF(2^8). It is the transmit-side counterpart of the Reed-Solomon decoder AFU.
- Accepts a byte stream of K message symbols and passes each one through with 1-cycle latency. After the last message symbol it appends 2T parity symbols.
- Sits between the read-path block buffer (S_RD_* FSM output, already unpacked to bytes) and the write-path packer feeding S_WR_DATA.
- Produces codewords that reed_solomon_decoder accepts with zero syndrome.

---
 rtl/reed_solomon_decoder_pkg.sv | 68 ++++++
 rtl/rs_gf_mult.sv | 22 ++
 rtl/reed_solomon_encoder.sv | 115 +++++++++++
 tb/tb_reed_solomon_encoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reed_solomon_decoder_pkg.sv
// -----------------------------------------------------------------------------
// reed_solomon_decoder_pkg
//   Shared RS(255,239) field and code definitions for the encoder and decoder.
//   Contents:
//     RS_SYM_W, RS_N, RS_K, RS_2T, RS_PRIM_POLY, RS_FCR : code parameters
//     t_rs_sym        : one GF(2^8) symbol
//     t_rs_gen        : packed array of the 2T non-leading generator coefficients
//     t_rs_enc_state  : encoder FSM states
//     gf_mul          : polynomial-basis GF(2^8) multiply reduced by prim
//     rs_gen_coef     : builds g(x) = prod_{i=0..2T-1} (x - alpha^(fcr+i))
//     RS_GEN_COEF     : generator coefficients for the default field
// -----------------------------------------------------------------------------
package reed_solomon_decoder_pkg;

    localparam int unsigned RS_SYM_W     = 8;
    localparam int unsigned RS_N         = 255;
    localparam int unsigned RS_K         = 239;
    localparam int unsigned RS_2T        = RS_N - RS_K;
    localparam logic [8:0]  RS_PRIM_POLY = 9'h11D;
    localparam int unsigned RS_FCR       = 0;

    typedef logic [RS_SYM_W-1:0] t_rs_sym;
    typedef t_rs_sym [RS_2T-1:0] t_rs_gen;

    typedef enum logic [1:0] {
        S_ENC_IDLE,
        S_ENC_DATA,
        S_ENC_PARITY
    } t_rs_enc_state;

    // Shift-and-add multiply; x is multiplied by alpha each step and reduced.
    function automatic t_rs_sym gf_mul(input t_rs_sym a, input t_rs_sym b,
                                       input logic [8:0] prim);
        t_rs_sym acc;
        t_rs_sym x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < RS_SYM_W; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[7] ? ((x << 1) ^ prim[7:0]) : (x << 1);
        end
        return acc;
    endfunction

    // Multiplies in one linear factor at a time; in characteristic 2 the
    // minus sign vanishes, so new_g[j] = g[j-1] ^ root*g[j].
    function automatic t_rs_gen rs_gen_coef(input logic [8:0] prim,
                                            input int unsigned fcr);
        t_rs_sym g [RS_2T+1];
        t_rs_sym root;
        t_rs_gen res;
        for (int unsigned j = 0; j <= RS_2T; j++) g[j] = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int unsigned k = 0; k < fcr; k++) root = gf_mul(root, 8'h02, prim);
        for (int unsigned i = 0; i < RS_2T; i++) begin
            for (int unsigned j = RS_2T; j >= 1; j--)
                g[j] = g[j-1] ^ gf_mul(root, g[j], prim);
            g[0] = gf_mul(root, g[0], prim);
            root = gf_mul(root, 8'h02, prim);
        end
        for (int unsigned j = 0; j < RS_2T; j++) res[j] = g[j];
        return res;
    endfunction

    localparam t_rs_gen RS_GEN_COEF = rs_gen_coef(RS_PRIM_POLY, RS_FCR);

endpackage

// File: rtl/rs_gf_mult.sv
// -----------------------------------------------------------------------------
// rs_gf_mult
//   Combinational 8x8 GF(2^8) multiplier, polynomial basis.
//   Ports:
//     a, b : operands
//     p    : a*b mod PRIM_POLY
// -----------------------------------------------------------------------------
module rs_gf_mult
    import reed_solomon_decoder_pkg::*;
#(
    parameter logic [8:0] PRIM_POLY = RS_PRIM_POLY
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    always_comb begin
        p = gf_mul(a, b, PRIM_POLY);
    end

endmodule

// File: rtl/reed_solomon_encoder.sv
// -----------------------------------------------------------------------------
// reed_solomon_encoder
//   Systematic RS(255,239) encoder. Message symbols pass through with one
//   cycle of latency; after the 239th symbol the 16 parity symbols follow.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     s_valid/s_ready    : input handshake, s_data = message symbol (MSB coef first)
//     m_valid/m_ready    : output handshake, m_data = codeword symbol
//     m_parity           : m_data is a parity symbol
//     m_last             : final parity symbol of the codeword
//     busy               : codeword in progress
//     cw_count           : completed codewords since reset (wraps)
// -----------------------------------------------------------------------------
module reed_solomon_encoder
    import reed_solomon_decoder_pkg::*;
#(
    parameter int unsigned SYM_W     = RS_SYM_W,
    parameter int unsigned RS_N      = 255,
    parameter int unsigned RS_K      = 239,
    parameter logic [8:0]  PRIM_POLY = RS_PRIM_POLY,
    parameter int unsigned FCR       = RS_FCR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SYM_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [SYM_W-1:0] m_data,
    output logic             m_parity,
    output logic             m_last,
    output logic             busy,
    output logic [31:0]      cw_count
);

    localparam int unsigned NPAR      = RS_N - RS_K;
    localparam t_rs_gen     GEN       = rs_gen_coef(PRIM_POLY, FCR);
    localparam logic [7:0]  LAST_DATA = 8'(RS_K - 1);
    localparam logic [7:0]  LAST_PAR  = 8'(NPAR - 1);

    t_rs_enc_state    state;
    logic [7:0]       sym_cnt;
    logic [SYM_W-1:0] par  [NPAR];
    logic [SYM_W-1:0] prod [NPAR];
    logic [SYM_W-1:0] fb;
    logic             out_free;

    always_comb begin
        out_free = !m_valid || m_ready;
        s_ready  = out_free && (state != S_ENC_PARITY);
        busy     = (state != S_ENC_IDLE);
        fb       = s_data ^ par[NPAR-1];
    end

    for (genvar i = 0; i < NPAR; i++) begin : g_mul
        rs_gf_mult #(.PRIM_POLY(PRIM_POLY)) u_mul (
            .a (fb),
            .b (GEN[i]),
            .p (prod[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_ENC_IDLE;
            sym_cnt  <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_parity <= 1'b0;
            m_last   <= 1'b0;
            cw_count <= '0;
            for (int unsigned i = 0; i < NPAR; i++) par[i] <= '0;
        end else if (out_free) begin
            if (state == S_ENC_PARITY) begin
                // Shifting zeros in leaves the register clean for the next codeword.
                m_data   <= par[NPAR-1];
                m_parity <= 1'b1;
                m_valid  <= 1'b1;
                for (int unsigned i = 1; i < NPAR; i++) par[i] <= par[i-1];
                par[0] <= '0;
                if (sym_cnt == LAST_PAR) begin
                    m_last   <= 1'b1;
                    cw_count <= cw_count + 32'd1;
                    state    <= S_ENC_IDLE;
                    sym_cnt  <= '0;
                end else begin
                    m_last  <= 1'b0;
                    sym_cnt <= sym_cnt + 8'd1;
                end
            end else if (s_valid) begin
                // s_ready is implied here: out_free and not in the parity phase.
                m_data   <= s_data;
                m_valid  <= 1'b1;
                m_parity <= 1'b0;
                m_last   <= 1'b0;
                for (int unsigned i = 1; i < NPAR; i++) par[i] <= par[i-1] ^ prod[i];
                par[0] <= prod[0];
                if (state == S_ENC_IDLE) begin
                    state   <= S_ENC_DATA;
                    sym_cnt <= 8'd1;
                end else if (sym_cnt == LAST_DATA) begin
                    state   <= S_ENC_PARITY;
                    sym_cnt <= '0;
                end else begin
                    sym_cnt <= sym_cnt + 8'd1;
                end
            end else begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reed_solomon_encoder.sv
module tb_reed_solomon_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_parity;
    logic        m_last;
    logic        busy;
    logic [31:0] cw_count;

    reed_solomon_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_parity (m_parity),
        .m_last   (m_last),
        .busy     (busy),
        .cw_count (cw_count)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          gexp [510];
    int          glog [256];
    int          gpoly [17];
    logic [7:0]  msg_q [$];
    logic [7:0]  od_q  [$];
    bit          op_q  [$];
    bit          ol_q  [$];
    int unsigned exp_cw;

    function automatic int fmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    // Field tables from repeated multiplication by alpha; g(x) as the product
    // of (x + alpha^i), i = 0..15, with index = power of x.
    task automatic init_field();
        int x = 1;
        for (int k = 0; k < 255; k++) begin
            gexp[k] = x;
            glog[x] = k;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        for (int k = 255; k < 510; k++) gexp[k] = gexp[k-255];
        for (int j = 0; j < 17; j++) gpoly[j] = 0;
        gpoly[0] = 1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j >= 1; j--) gpoly[j] = gpoly[j-1] ^ fmul(gexp[i], gpoly[j]);
            gpoly[0] = fmul(gexp[i], gpoly[0]);
        end
    endtask

    task automatic note_fail(input string name, input int act, input int req);
        miscompares++;
        if (miscompares <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Codeword c: reference by long division of m(x)*x^16 by g(x); the received
    // codeword must also evaluate to zero at alpha^0..alpha^15.
    task automatic check_cw(input int c);
        int r [255];
        int base = c * 239;
        int ob   = c * 255;
        int coef;
        int s;
        int expd;
        for (int k = 0; k < 239; k++) r[254-k] = int'(msg_q[base+k]);
        for (int k = 0; k < 16; k++) r[k] = 0;
        for (int deg = 254; deg >= 16; deg--) begin
            coef = r[deg];
            if (coef != 0)
                for (int j = 0; j <= 16; j++) r[deg-16+j] = r[deg-16+j] ^ fmul(coef, gpoly[j]);
        end
        for (int p = 0; p < 255; p++) begin
            expd = (p < 239) ? int'(msg_q[base+p]) : r[254-p];
            vectors++;
            if (od_q[ob+p] !== 8'(expd)) note_fail($sformatf("cw%0d_sym%0d", c, p), int'(od_q[ob+p]), expd);
            vectors++;
            if (op_q[ob+p] !== (p >= 239)) note_fail($sformatf("cw%0d_parity_flag%0d", c, p), int'(op_q[ob+p]), int'(p >= 239));
            vectors++;
            if (ol_q[ob+p] !== (p == 254)) note_fail($sformatf("cw%0d_last_flag%0d", c, p), int'(ol_q[ob+p]), int'(p == 254));
        end
        for (int i = 0; i < 16; i++) begin
            s = 0;
            for (int p = 0; p < 255; p++) s = fmul(s, gexp[i]) ^ int'(od_q[ob+p]);
            vectors++;
            if (s != 0) note_fail($sformatf("cw%0d_syndrome%0d", c, i), s, 0);
        end
    endtask

    task automatic stream(input int n_cw, input int rdy_pct, input int vld_pct, input bit chk_sready);
        int         idx    = 0;
        int         n_in   = n_cw * 239;
        int         n_out  = n_cw * 255;
        int         budget = n_out * 20 + 100;
        int         cyc    = 0;
        int         low    = 0;
        bit         hold   = 0;
        logic [7:0] hd     = '0;
        logic       hp     = 0;
        logic       hl     = 0;
        od_q.delete();
        op_q.delete();
        ol_q.delete();
        while (od_q.size() < n_out && cyc < budget) begin
            @(negedge clk);
            cyc++;
            m_ready = ($urandom_range(99) < rdy_pct);
            if (idx < n_in && $urandom_range(99) < vld_pct) begin
                s_valid = 1'b1;
                s_data  = msg_q[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
            #1;
            if (hold) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== hd || m_parity !== hp || m_last !== hl)
                    note_fail("stall_hold", int'({m_valid, m_parity, m_last, m_data}), int'({1'b1, hp, hl, hd}));
            end
            hold = m_valid && !m_ready;
            hd   = m_data;
            hp   = m_parity;
            hl   = m_last;
            if (!s_ready) low++;
            if (m_valid && m_ready) begin
                od_q.push_back(m_data);
                op_q.push_back(m_parity);
                ol_q.push_back(m_last);
            end
            if (s_valid && s_ready) idx++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        vectors++;
        if (od_q.size() != n_out) begin
            note_fail("timeout_outputs", od_q.size(), n_out);
        end else begin
            for (int c = 0; c < n_cw; c++) check_cw(c);
        end
        if (chk_sready) begin
            vectors++;
            if (low != 16 * n_cw) note_fail("s_ready_low_cycles", low, 16 * n_cw);
        end
        exp_cw = exp_cw + 32'(n_cw);
        vectors++;
        if (cw_count !== exp_cw) note_fail("cw_count", int'(cw_count), int'(exp_cw));
    endtask

    task automatic fill_msgs(input int n_cw);
        msg_q.delete();
        for (int k = 0; k < n_cw * 239; k++) msg_q.push_back(8'($urandom));
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if (m_valid !== 1'b0) note_fail({tag, "_m_valid"}, int'(m_valid), 0);
        vectors++;
        if (m_data !== 8'h00) note_fail({tag, "_m_data"}, int'(m_data), 0);
        vectors++;
        if (m_parity !== 1'b0 || m_last !== 1'b0) note_fail({tag, "_flags"}, int'({m_parity, m_last}), 0);
        vectors++;
        if (busy !== 1'b0) note_fail({tag, "_busy"}, int'(busy), 0);
        vectors++;
        if (cw_count !== 32'd0) note_fail({tag, "_cw_count"}, int'(cw_count), 0);
        vectors++;
        if (s_ready !== 1'b1) note_fail({tag, "_s_ready"}, int'(s_ready), 1);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n  = 1'b1;
        exp_cw = 0;
    endtask

    task automatic test_all_zero();
        msg_q.delete();
        for (int k = 0; k < 239; k++) msg_q.push_back(8'h00);
        stream(1, 100, 100, 1);
    endtask

    task automatic test_impulse();
        msg_q.delete();
        for (int k = 0; k < 238; k++) msg_q.push_back(8'h00);
        msg_q.push_back(8'h01);
        stream(1, 100, 100, 1);
        if (od_q.size() == 255)
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if (od_q[239+k] !== 8'(gpoly[15-k])) note_fail($sformatf("impulse_gen%0d", 15-k), int'(od_q[239+k]), gpoly[15-k]);
            end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        exp_cw = 0;
        fill_msgs(100);
        stream(100, 100, 100, 1);
    endtask

    task automatic test_stall();
        fill_msgs(3);
        stream(3, 30, 70, 0);
    endtask

    task automatic test_mid_reset();
        int idx = 0;
        int cyc = 0;
        fill_msgs(1);
        while (idx < 100 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            s_valid = 1'b1;
            s_data  = msg_q[idx];
            m_ready = 1'b1;
            #1;
            if (s_ready) idx++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1 || idx != 100) note_fail("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n  = 1'b1;
        exp_cw = 0;
        fill_msgs(1);
        stream(1, 100, 100, 1);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.cw_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cw_count;
        exp_cw = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if (cw_count !== exp_cw) note_fail("wrap_preload", int'(cw_count), int'(exp_cw));
        fill_msgs(1);
        stream(1, 100, 100, 1);
        fill_msgs(1);
        stream(1, 100, 100, 1);
    endtask

    initial begin
        init_field();
        test_reset();
        test_all_zero();
        test_impulse();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
